// File: rtl/pht_update_queue_pkg.sv
`default_nettype none
// pht_update_queue_pkg: shared types, sizes and the 2-bit counter update for the PHT update path.
// Rev 1.0
package pht_update_queue_pkg;

  localparam int PHT_QUEUE_SIZE  = 32;
  localparam int PHT_INDEX_BITS  = 10;
  localparam int PHT_ENTRY_WIDTH = 2;

  localparam logic [PHT_ENTRY_WIDTH-1:0] PHT_ENTRY_MAX  = '1;
  localparam logic [PHT_ENTRY_WIDTH-1:0] PHT_INIT_VALUE = (PHT_ENTRY_MAX >> 1) + 1'b1;

  typedef struct packed {
    logic [PHT_INDEX_BITS-1:0]  index;
    logic [PHT_ENTRY_WIDTH-1:0] value;
  } pht_update_entry_t;

  // Saturating counter step; never wraps at either end.
  function automatic logic [PHT_ENTRY_WIDTH-1:0] ctr_update(
    input logic [PHT_ENTRY_WIDTH-1:0] prev,
    input logic                       taken
  );
    if (taken) return (prev == PHT_ENTRY_MAX) ? prev : prev + 1'b1;
    else       return (prev == '0)            ? prev : prev - 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pht_update_queue_ptr.sv
`default_nettype none
// pht_update_queue_ptr: wrap-bit head/tail pointers with multi-push and single pop.
// Rev 1.0
module pht_update_queue_ptr #(
  parameter int DEPTH    = 32,
  parameter int PUSH_NUM = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(PUSH_NUM+1)-1:0] push_num,
  input  logic                          pop,
  output logic [$clog2(DEPTH)-1:0]      head_idx,
  output logic [$clog2(DEPTH)-1:0]      tail_idx,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          empty
);

  localparam int AW = $clog2(DEPTH);

  // Head is the write side, tail the read side; bit AW is the wrap bit.
  logic [AW:0] head;
  logic [AW:0] tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head + (AW+1)'(push_num);
      if (pop) tail <= tail + 1'b1;
    end
  end

  assign head_idx = head[AW-1:0];
  assign tail_idx = tail[AW-1:0];
  assign count    = head - tail;
  assign empty    = (head == tail);

endmodule
`default_nettype wire

// File: rtl/pht_update_queue.sv
`default_nettype none
// pht_update_queue: merges per-lane branch results into one PHT write per cycle, queuing the rest,
// and sweeps the PHT with the weakly-taken value while in reset.  Rev 1.0
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter int LANE_NUM    = 2,
  parameter int QUEUE_DEPTH = PHT_QUEUE_SIZE,
  parameter int INDEX_BITS  = PHT_INDEX_BITS,
  parameter int CTR_BITS    = PHT_ENTRY_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rstStart,
  input  logic [LANE_NUM-1:0]                  brValid,
  input  logic [LANE_NUM-1:0][INDEX_BITS-1:0]  brIndex,
  input  logic [LANE_NUM-1:0][CTR_BITS-1:0]    brPrevValue,
  input  logic [LANE_NUM-1:0]                  brExecTaken,
  output logic                                 phtWE,
  output logic [INDEX_BITS-1:0]                phtWA,
  output logic [CTR_BITS-1:0]                  phtWV,
  output logic [$clog2(QUEUE_DEPTH):0]         queueCount,
  output logic                                 overflowDrop
);

  localparam int AW  = $clog2(QUEUE_DEPTH);
  localparam int PNW = $clog2(LANE_NUM+1);

  pht_update_entry_t                  mem [QUEUE_DEPTH];
  logic [INDEX_BITS-1:0]              sweep_idx;
  logic [LANE_NUM-1:0]                valid;
  logic [LANE_NUM-1:0][CTR_BITS-1:0]  new_val;
  logic [LANE_NUM-1:0]                push_en;
  logic [LANE_NUM-1:0][AW-1:0]        push_slot;
  logic [PNW-1:0]                     push_num;
  logic [AW:0]                        running;
  logic [AW-1:0]                      head_idx;
  logic [AW-1:0]                      tail_idx;
  logic [AW:0]                        count;
  logic                               empty;
  logic                               any_valid;
  logic                               drop;
  logic                               pop;
  pht_update_entry_t                  direct;

  assign valid = brValid & {LANE_NUM{~rst}};

  always_comb begin
    for (int l = 0; l < LANE_NUM; l++) new_val[l] = ctr_update(brPrevValue[l], brExecTaken[l]);
  end

  // Lowest valid lane owns the direct write; same-index lanes fold into it, the rest queue
  // in lane order, each checked against the count including earlier pushes this cycle.
  always_comb begin
    any_valid = 1'b0;
    direct    = '0;
    push_en   = '0;
    push_slot = '0;
    push_num  = '0;
    drop      = 1'b0;
    running   = count;
    for (int l = 0; l < LANE_NUM; l++) begin
      if (valid[l]) begin
        if (!any_valid) begin
          any_valid    = 1'b1;
          direct.index = brIndex[l];
          direct.value = new_val[l];
        end else if (brIndex[l] == direct.index) begin
          direct.value = new_val[l];
        end else if (running < (AW+1)'(QUEUE_DEPTH)) begin
          push_en[l]   = 1'b1;
          push_slot[l] = head_idx + AW'(push_num);
          push_num     = push_num + 1'b1;
          running      = running + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  assign pop = ~rst & ~any_valid & ~empty;

  pht_update_queue_ptr #(
    .DEPTH    (QUEUE_DEPTH),
    .PUSH_NUM (LANE_NUM)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .push_num (push_num),
    .pop      (pop),
    .head_idx (head_idx),
    .tail_idx (tail_idx),
    .count    (count),
    .empty    (empty)
  );

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANE_NUM; l++) begin
      if (push_en[l]) mem[push_slot[l]] <= '{index: brIndex[l], value: new_val[l]};
    end
  end

  always_ff @(posedge clk) begin
    if (rstStart)  sweep_idx <= '0;
    else if (rst)  sweep_idx <= sweep_idx + 1'b1;
  end

  always_comb begin
    phtWE = 1'b0;
    phtWA = '0;
    phtWV = '0;
    if (rst) begin
      phtWE = 1'b1;
      phtWA = sweep_idx;
      phtWV = PHT_INIT_VALUE;
    end else if (any_valid) begin
      phtWE = 1'b1;
      phtWA = direct.index;
      phtWV = direct.value;
    end else if (!empty) begin
      phtWE = 1'b1;
      phtWA = mem[tail_idx].index;
      phtWV = mem[tail_idx].value;
    end
  end

  assign queueCount   = rst ? '0 : count;
  assign overflowDrop = drop;

endmodule
`default_nettype wire

// File: tb/tb_pht_update_queue.sv
`default_nettype none
// tb_pht_update_queue: directed vector table plus hand-written sweep, full and reset sequences.
// Rev 1.0
module tb_pht_update_queue;

  logic             clk = 1'b0;
  logic             rst;
  logic             rstStart;
  logic [1:0]       brValid;
  logic [1:0][9:0]  brIndex;
  logic [1:0][1:0]  brPrevValue;
  logic [1:0]       brExecTaken;
  logic             phtWE;
  logic [9:0]       phtWA;
  logic [1:0]       phtWV;
  logic [5:0]       queueCount;
  logic             overflowDrop;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pht_update_queue dut (
    .clk          (clk),
    .rst          (rst),
    .rstStart     (rstStart),
    .brValid      (brValid),
    .brIndex      (brIndex),
    .brPrevValue  (brPrevValue),
    .brExecTaken  (brExecTaken),
    .phtWE        (phtWE),
    .phtWA        (phtWA),
    .phtWV        (phtWV),
    .queueCount   (queueCount),
    .overflowDrop (overflowDrop)
  );

  typedef struct {
    logic [1:0] v;
    logic [9:0] i0, i1;
    logic [1:0] p0, p1;
    logic       t0, t1;
    logic       we;
    logic [9:0] wa;
    logic [1:0] wv;
    int         cnt;
    logic       drop;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [1:0] model_ctr(input int p, input bit t);
    int r;
    if (t) r = (p >= 3) ? 3 : p + 1;
    else   r = (p <= 0) ? 0 : p - 1;
    return 2'(r);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [9:0] i0, input logic [9:0] i1,
                       input logic [1:0] p0, input logic [1:0] p1, input logic t0, input logic t1);
    brValid        = v;
    brIndex[0]     = i0;
    brIndex[1]     = i1;
    brPrevValue[0] = p0;
    brPrevValue[1] = p1;
    brExecTaken[0] = t0;
    brExecTaken[1] = t1;
  endtask

  int seen[1024];
  int sweep_err;
  int cover_err;

  initial begin
    rst = 1'b1;
    rstStart = 1'b0;
    drive(2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
    tick(); tick();

    // Reset sweep
    rstStart = 1'b1;
    tick();
    rstStart = 1'b0;
    for (int i = 0; i < 1024; i++) seen[i] = 0;
    sweep_err = 0;
    for (int c = 0; c < 1024; c++) begin
      #2;
      if (phtWE !== 1'b1 || phtWV !== 2'b10 || queueCount !== 6'd0 || overflowDrop !== 1'b0)
        sweep_err++;
      seen[phtWA]++;
      tick();
    end
    cover_err = 0;
    for (int i = 0; i < 1024; i++) if (seen[i] != 1) cover_err++;
    chk("sweep_we_wv", sweep_err, 0);
    chk("sweep_cover", cover_err, 0);
    rst = 1'b0;
    tick();
    #2;
    chk("post_rst_we", phtWE, 0);
    chk("post_rst_wa", phtWA, 0);
    chk("post_rst_wv", phtWV, 0);
    chk("post_rst_cnt", queueCount, 0);
    chk("post_rst_drop", overflowDrop, 0);
    tick();

    // Directed single-cycle vectors
    vecs[0]  = '{2'b00, 10'h000, 10'h000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h000, 2'd0, 0, 1'b0};
    vecs[1]  = '{2'b01, 10'h005, 10'h000, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 10'h005, 2'd3, 0, 1'b0};
    vecs[2]  = '{2'b00, 10'h000, 10'h000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h000, 2'd0, 0, 1'b0};
    vecs[3]  = '{2'b11, 10'h010, 10'h020, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1, 10'h010, 2'd0, 0, 1'b0};
    vecs[4]  = '{2'b00, 10'h000, 10'h000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 10'h020, 2'd2, 1, 1'b0};
    vecs[5]  = '{2'b00, 10'h000, 10'h000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h000, 2'd0, 0, 1'b0};
    vecs[6]  = '{2'b11, 10'h033, 10'h033, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1, 10'h033, 2'd3, 0, 1'b0};
    vecs[7]  = '{2'b00, 10'h000, 10'h000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h000, 2'd0, 0, 1'b0};
    vecs[8]  = '{2'b10, 10'h111, 10'h3FF, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 10'h3FF, 2'd0, 0, 1'b0};
    vecs[9]  = '{2'b01, 10'h001, 10'h000, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 10'h001, 2'd1, 0, 1'b0};
    vecs[10] = '{2'b00, 10'h000, 10'h000, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 10'h000, 2'd0, 0, 1'b0};
    for (int k = 0; k < 11; k++) begin
      drive(vecs[k].v, vecs[k].i0, vecs[k].i1, vecs[k].p0, vecs[k].p1, vecs[k].t0, vecs[k].t1);
      #2;
      chk($sformatf("vec%0d_we", k), phtWE, vecs[k].we);
      chk($sformatf("vec%0d_wa", k), phtWA, vecs[k].wa);
      chk($sformatf("vec%0d_wv", k), phtWV, vecs[k].wv);
      chk($sformatf("vec%0d_cnt", k), queueCount, vecs[k].cnt);
      chk($sformatf("vec%0d_drop", k), overflowDrop, vecs[k].drop);
      tick();
    end

    // Fill to full, overflow on the 33rd push, then drain in push order
    for (int k = 0; k < 33; k++) begin
      drive(2'b11, 10'(2*k), 10'(2*k+1), 2'd1, 2'(k % 4), 1'b1, k[0]);
      #2;
      chk($sformatf("fill%0d_cnt", k), queueCount, (k < 32) ? k : 32);
      chk($sformatf("fill%0d_drop", k), overflowDrop, (k == 32) ? 1 : 0);
      chk($sformatf("fill%0d_wa", k), phtWA, 2*k);
      chk($sformatf("fill%0d_wv", k), phtWV, model_ctr(1, 1'b1));
      tick();
    end
    drive(2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      #2;
      chk($sformatf("drain%0d_cnt", k), queueCount, 32 - k);
      chk($sformatf("drain%0d_we", k), phtWE, 1);
      chk($sformatf("drain%0d_wa", k), phtWA, 2*k+1);
      chk($sformatf("drain%0d_wv", k), phtWV, model_ctr(k % 4, k[0]));
      chk($sformatf("drain%0d_drop", k), overflowDrop, 0);
      tick();
    end
    #2;
    chk("drained_cnt", queueCount, 0);
    chk("drained_we", phtWE, 0);
    tick();

    // Mid-operation reset discards five queued entries
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, 10'(10'h100 + k), 10'(10'h200 + k), 2'd0, 2'd0, 1'b1, 1'b1);
      #2;
      chk($sformatf("mr_push%0d_cnt", k), queueCount, k);
      tick();
    end
    drive(2'b11, 10'h2AA, 10'h2BB, 2'd0, 2'd0, 1'b1, 1'b1);
    rst = 1'b1;
    #2;
    chk("mr_rst_cnt", queueCount, 0);
    chk("mr_rst_wv", phtWV, 2);
    chk("mr_rst_drop", overflowDrop, 0);
    tick();
    rst = 1'b0;
    drive(2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      #2;
      chk($sformatf("mr_after%0d_cnt", k), queueCount, 0);
      chk($sformatf("mr_after%0d_we", k), phtWE, 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
